// File: rtl/alu_pkg.sv
// Shared widths, issue-state encoding and op-entry layout for the ALU issue unit.
// Entry layout (MSB..LSB): {a, b, sel, tag}.
package alu_pkg;
    localparam int OPW  = 4;
    localparam int SELW = 3;
    localparam int RESW = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_RESULT = 2'd2
    } issue_state_t;

    function automatic int entry_w(input int tagw);
        return 2 * OPW + SELW + tagw;
    endfunction
endpackage

// File: rtl/alu_op_fifo.sv
// Synchronous FIFO holding queued ALU operations; head entry is read combinationally.
module alu_op_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 15
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// File: rtl/alu_issue_unit.sv
// Issue stage: queues ops, drives registered operands to the external ALU, captures y after SETTLE cycles.
// States: IDLE pop head when queue non-empty | DRIVE hold alu_* until settled | RESULT present result until taken.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1,
    parameter int TAGW   = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [OPW-1:0]  i_in_a,
    input  logic [OPW-1:0]  i_in_b,
    input  logic [SELW-1:0] i_in_sel,
    output logic [OPW-1:0]  o_alu_a,
    output logic [OPW-1:0]  o_alu_b,
    output logic [SELW-1:0] o_alu_sel,
    input  logic [RESW-1:0] i_alu_y,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [RESW-1:0] o_out_y,
    output logic [SELW-1:0] o_out_sel,
    output logic [TAGW-1:0] o_out_tag,
    output logic            o_busy
);
    localparam int EW = entry_w(TAGW);
    localparam int CW = $clog2(DEPTH) + 1;

    issue_state_t    r_state;
    issue_state_t    w_next_state;
    logic            w_push;
    logic            w_pop;
    logic [EW-1:0]   w_head;
    logic [CW-1:0]   w_count;
    logic            w_full;
    logic            w_empty;
    logic [TAGW-1:0] r_tag_ctr;
    logic [TAGW-1:0] r_tag;
    logic [3:0]      r_wait;
    logic [OPW-1:0]  r_alu_a;
    logic [OPW-1:0]  r_alu_b;
    logic [SELW-1:0] r_alu_sel;
    logic            r_out_valid;
    logic [RESW-1:0] r_out_y;
    logic [SELW-1:0] r_out_sel;
    logic [TAGW-1:0] r_out_tag;

    assign o_in_ready = ~w_full;
    assign w_push     = i_in_valid & ~w_full;

    alu_op_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  ({i_in_a, i_in_b, i_in_sel, r_tag_ctr}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_DRIVE;
                end
            end
            ST_DRIVE:  if (r_wait == 4'd0) w_next_state = ST_RESULT;
            ST_RESULT: if (i_out_ready)    w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tag_ctr   <= '0;
            r_tag       <= '0;
            r_wait      <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= '0;
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_out_sel   <= '0;
            r_out_tag   <= '0;
        end else begin
            if (w_push) r_tag_ctr <= r_tag_ctr + 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        {r_alu_a, r_alu_b, r_alu_sel, r_tag} <= w_head;
                        r_wait <= 4'(SETTLE - 1);
                    end
                end
                ST_DRIVE: begin
                    if (r_wait == 4'd0) begin
                        r_out_y     <= i_alu_y;
                        r_out_sel   <= r_alu_sel;
                        r_out_tag   <= r_tag;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                ST_RESULT: if (i_out_ready) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;
    assign o_alu_sel   = r_alu_sel;
    assign o_out_valid = r_out_valid;
    assign o_out_y     = r_out_y;
    assign o_out_sel   = r_out_sel;
    assign o_out_tag   = r_out_tag;
    assign o_busy      = (w_count != '0) | (r_state != ST_IDLE);
endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: scoreboarded SETTLE=1 instance plus a SETTLE=3 instance for timing/reset checks.
module tb_alu_issue_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid, out_ready, in_ready, out_valid, busy;
    logic [3:0] in_a, in_b, alu_a, alu_b, out_tag;
    logic [2:0] in_sel, alu_sel, out_sel;
    logic [4:0] alu_y, out_y;

    logic       in_valid2, out_ready2, in_ready2, out_valid2, busy2, corrupt;
    logic [3:0] in_a2, in_b2, alu_a2, alu_b2, out_tag2;
    logic [2:0] in_sel2, alu_sel2, out_sel2;
    logic [4:0] alu_y2, out_y2;

    assign alu_y  = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_y2 = corrupt ? 5'h1F : ({1'b0, alu_a2} + {1'b0, alu_b2});

    alu_issue_unit #(.DEPTH(4), .SETTLE(1), .TAGW(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_a(in_a), .i_in_b(in_b), .i_in_sel(in_sel),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_sel(alu_sel), .i_alu_y(alu_y),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_y(out_y),
        .o_out_sel(out_sel), .o_out_tag(out_tag), .o_busy(busy)
    );

    alu_issue_unit #(.DEPTH(4), .SETTLE(3), .TAGW(4)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid2), .o_in_ready(in_ready2),
        .i_in_a(in_a2), .i_in_b(in_b2), .i_in_sel(in_sel2),
        .o_alu_a(alu_a2), .o_alu_b(alu_b2), .o_alu_sel(alu_sel2), .i_alu_y(alu_y2),
        .o_out_valid(out_valid2), .i_out_ready(out_ready2), .o_out_y(out_y2),
        .o_out_sel(out_sel2), .o_out_tag(out_tag2), .o_busy(busy2)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] exp_q[$];
    logic [3:0]  exp_tag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a handshake happens on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got y=%0d sel=%0d tag=%0d, expected no result", out_y, out_sel, out_tag);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                check("sb_result{y,sel,tag}", {20'd0, out_y, out_sel, out_tag}, {20'd0, e});
            end
        end
    end

    task automatic push1(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        int t;
        logic [4:0] y;
        in_a = a; in_b = b; in_sel = s; in_valid = 1'b1; t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL push_timeout: got in_ready=0 after %0d cycles, expected 1", t);
        end else begin
            y = {1'b0, a} + {1'b0, b};
            exp_q.push_back({y, s, exp_tag});
            exp_tag = exp_tag + 4'd1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic push2(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        int t;
        in_a2 = a; in_b2 = b; in_sel2 = s; in_valid2 = 1'b1; t = 0;
        while (!in_ready2 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        check("push2_ready", {31'd0, in_ready2}, 32'd1);
        @(posedge clk); #1;
        in_valid2 = 1'b0;
    endtask

    task automatic wait_idle1(input int budget);
        int t;
        t = 0;
        while (busy && t < budget) begin
            @(posedge clk); #1; t++;
        end
        check("idle_timeout_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_valid1(input int budget);
        int t;
        t = 0;
        while (!out_valid && t < budget) begin
            @(posedge clk); #1; t++;
        end
        check("valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        exp_tag = 4'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int t;
        in_valid = 0; out_ready = 0; in_a = 0; in_b = 0; in_sel = 0;
        in_valid2 = 0; out_ready2 = 0; in_a2 = 0; in_b2 = 0; in_sel2 = 0;
        corrupt = 0; exp_tag = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_alu", {21'd0, alu_a, alu_b, alu_sel}, 32'd0);
        check("rst_out", {20'd0, out_y, out_sel, out_tag}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single operation, latency check
        push1(4'd8, 4'd4, 3'd6);
        @(posedge clk); #1;
        check("single_alu{a,b,sel}", {21'd0, alu_a, alu_b, alu_sel}, {21'd0, 4'd8, 4'd4, 3'd6});
        check("single_valid_early", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("single_valid", {31'd0, out_valid}, 32'd1);
        check("single_out{y,sel,tag}", {20'd0, out_y, out_sel, out_tag}, {20'd0, 5'd12, 3'd6, 4'd0});
        out_ready = 1'b1;
        wait_idle1(20);
        out_ready = 1'b0;

        // Burst to full under back-pressure
        do_reset();
        push1(4'd10, 4'd1, 3'd1);
        push1(4'd7, 4'd5, 3'd3);
        push1(4'd8, 4'd4, 3'd6);
        push1(4'd1, 4'd1, 3'd1);
        push1(4'd2, 4'd2, 3'd2);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        in_a = 4'd9; in_b = 4'd9; in_sel = 3'd7; in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("full_stall", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;

        // Hold in RESULT for 10 cycles
        repeat (10) begin
            @(posedge clk); #1;
            check("hold{valid,y,tag,a,sel}", {15'd0, out_valid, out_y, out_tag, alu_a, alu_sel},
                  {15'd0, 1'b1, 5'd11, 4'd0, 4'd10, 3'd1});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("one_hs_valid", {31'd0, out_valid}, 32'd0);
        check("one_hs_pending", exp_q.size(), 32'd4);
        repeat (4) begin
            wait_valid1(20);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        wait_idle1(20);
        check("burst_drained", exp_q.size(), 32'd0);

        // Settle interval on the SETTLE=3 instance
        push2(4'd7, 4'd5, 3'd3);
        corrupt = 1'b1;
        @(posedge clk); #1;
        check("settle_alu_a", {28'd0, alu_a2}, 32'd7);
        check("settle_valid_e1", {31'd0, out_valid2}, 32'd0);
        @(posedge clk); #1;
        check("settle_valid_e2", {31'd0, out_valid2}, 32'd0);
        @(posedge clk); #1;
        check("settle_valid_e3", {31'd0, out_valid2}, 32'd0);
        corrupt = 1'b0;
        @(posedge clk); #1;
        check("settle_valid_e4", {31'd0, out_valid2}, 32'd1);
        check("settle_out{y,tag}", {23'd0, out_y2, out_tag2}, {23'd0, 5'd12, 4'd0});
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
        check("settle_taken", {31'd0, out_valid2}, 32'd0);

        // Tag wrap with out_ready tied high
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) push1(4'(i), 4'(3 * i), 3'(i));
        wait_idle1(100);
        out_ready = 1'b0;
        check("wrap_drained", exp_q.size(), 32'd0);

        // Reset during DRIVE with two queued entries
        push2(4'd1, 4'd2, 3'd1);
        push2(4'd3, 4'd4, 3'd2);
        push2(4'd5, 4'd6, 3'd3);
        check("pre_rst_busy", {31'd0, busy2}, 32'd1);
        #2 rst = 1'b1;
        exp_q.delete();
        exp_tag = 4'd0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid2}, 32'd0);
        check("mid_rst_alu", {21'd0, alu_a2, alu_b2, alu_sel2}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready2}, 32'd1);
        check("mid_rst_busy", {31'd0, busy2}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        push2(4'd3, 4'd3, 3'd5);
        t = 0;
        while (!out_valid2 && t < 20) begin
            @(posedge clk); #1; t++;
        end
        check("post_rst_out{valid,y,sel,tag}", {19'd0, out_valid2, out_y2, out_sel2, out_tag2},
              {19'd0, 1'b1, 5'd6, 3'd5, 4'd0});
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
        check("post_rst_busy", {31'd0, busy2}, 32'd0);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
